undo_restore_scheduler: RTL and testbench
=========================================

Name: undo_restore_scheduler

Overview:
- Sits between the commit queue's abort path and the undo-log restore engine.
- Collects abort requests per CQ slice slot into a pending bitmap, coalescing duplicates.
- Issues restores round-robin with a bound on the number in flight.
- Returns completions to the commit queue through a small done FIFO.

Parameters:
LOG_SLOTS, 6, log2 of CQ slice slots tracked (bitmap width 2**LOG_SLOTS)
MAX_INFLIGHT, 4, maximum restores issued but not yet completed (1..2**LOG_SLOTS)
DONE_FIFO_DEPTH, 4, depth of completion FIFO (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
abort_valid  in  1  abort request from commit queue
abort_ready  out  1  always 1 out of reset; 0 while rst asserted
abort_slot  in  LOG_SLOTS  CQ slot to roll back
restore_valid  out  1  restore request to undo log
restore_ready  in  1  undo log accepts request
restore_slot  out  LOG_SLOTS  slot to restore
restore_done_valid  in  1  undo log finished a restore
restore_done_ready  out  1  = done FIFO not full
restore_done_slot  in  LOG_SLOTS  slot finished
abort_done_valid  out  1  completion to commit queue
abort_done_ready  in  1  commit queue accepts completion
abort_done_slot  out  LOG_SLOTS  completed slot
inflight_count  out  $clog2(MAX_INFLIGHT+1)  restores outstanding
pending_count  out  LOG_SLOTS+1  set bits in pending bitmap
idle  out  1  pending, inflight and FIFO all empty
err_spurious_done  out  1  sticky; done for slot not in flight

Behaviour:
- rst (async, active-high) clears:
  - pending and inflight bitmaps, RR pointer, FIFO
  - restore_valid, abort_done_valid, err_spurious_done, all counts
- During reset: idle=0 and abort_ready=0. After deassertion: idle=1.
- Abort accept (abort_valid & abort_ready):
  - Set pending[abort_slot] unless pending[abort_slot] or inflight_eff[abort_slot]. Otherwise coalesce (drop).
  - inflight_eff = inflight with this cycle's accepted done slot cleared. An abort on a slot whose done is accepted the same cycle therefore becomes pending.
- Issue FSM, state ISS_IDLE / ISS_HOLD:
  - ISS_IDLE: if pending != 0 and inflight_count < MAX_INFLIGHT:
    - select the first set pending bit at or after rr_ptr, wrapping modulo 2**LOG_SLOTS
    - register it to restore_slot, assert restore_valid, clear its pending bit, set its inflight bit
    - set rr_ptr = selected+1 (wraps); go to ISS_HOLD
  - ISS_HOLD: restore_valid and restore_slot are held stable until restore_ready. On handshake, drop restore_valid and return to ISS_IDLE.
  - Minimum issue interval is 2 cycles. Latency from abort accept to restore_valid is 1 cycle when a slot is free.
- inflight_count is incremented at issue selection, not at handshake, so the cap holds while a request is held. Simultaneous issue and done give a net count of 0.
- Done (restore_done_valid & restore_done_ready):
  - If inflight[slot]: clear the bit, decrement the count, push slot to the FIFO.
  - Otherwise: set err_spurious_done, push nothing, leave the count unchanged.
- Done FIFO:
  - abort_done_valid = FIFO non-empty; abort_done_slot = head.
  - Pop on abort_done_ready. Push and pop in the same cycle are allowed when full.
  - restore_done_ready = !full, or (full & pop this cycle).
- pending_count and inflight_count are registered. pending_count updates every cycle abort-set or issue-clear occurs; both in one cycle give a net of 0.
- idle = (pending==0) & (inflight==0) & FIFO empty & !restore_valid.

Optional Feature:
RESTORE_SCHED_STATS_EN:
- Defined: adds 32-bit outputs stat_issued, stat_coalesced, stat_completed.
  - Counts, in order: restore handshakes, dropped duplicate aborts, FIFO pushes.
  - Each saturates at 2**32-1 and is cleared by rst.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
1. Single abort slot 5, restore_ready=1 -> restore_valid next cycle with slot 5. Then restore_done slot 5 -> abort_done_valid slot 5 one cycle later; idle returns to 1.
2. Aborts slots 1,2,3,4,5,6 back-to-back with no done, MAX_INFLIGHT=4 -> exactly slots 1,2,3,4 issued in that order; inflight_count=4, pending_count=2. Done slot 2 -> slot 5 issued.
3. Abort slot 9 twice, second while 9 is pending, then once while 9 is in flight -> one restore issued, pending_count stays 1; with stats, stat_coalesced=2.
4. Round-robin wrap: rr_ptr=62 (issue slot 61 first), then pending {0,63} -> issue 63 then 0.
5. abort_done_ready=0, five dones with DONE_FIFO_DEPTH=4 -> restore_done_ready=0 on fifth. Release ready -> slots pop in arrival order; fifth accepted the first cycle a pop occurs.
6. restore_done slot 12 never issued -> err_spurious_done=1 sticky, no abort_done. Assert rst mid-ISS_HOLD -> restore_valid=0 and idle=0 during rst; idle=1 after release.

Source files
------------

// File: rtl/undo_restore_scheduler.sv
// undo_restore_scheduler
//   Collects commit-queue abort requests into a per-slot pending bitmap,
//   coalescing duplicates. Issues undo-log restores round-robin with at most
//   MAX_INFLIGHT outstanding. Returns completions to the commit queue through
//   a small done FIFO.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   abort_valid/ready/slot        abort requests from the commit queue
//   restore_valid/ready/slot      restore requests to the undo log
//   restore_done_valid/ready/slot restore completions from the undo log
//   abort_done_valid/ready/slot   completions back to the commit queue
//   inflight_count, pending_count registered occupancy counts
//   idle                          nothing pending, in flight or queued
//   err_spurious_done             sticky: done seen for a slot not in flight
//
// Optional build macro
//   RESTORE_SCHED_STATS_EN        adds saturating stat_issued, stat_coalesced
//                                 and stat_completed counters and ports
//
// Issue FSM states
//   ISS_IDLE | no request presented; may select a slot this cycle
//   ISS_HOLD | restore_valid high, slot held until restore_ready
module undo_restore_scheduler #(
  parameter int LOG_SLOTS       = 6,
  parameter int MAX_INFLIGHT    = 4,
  parameter int DONE_FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               abort_valid,
  output logic                               abort_ready,
  input  logic [LOG_SLOTS-1:0]               abort_slot,
  output logic                               restore_valid,
  input  logic                               restore_ready,
  output logic [LOG_SLOTS-1:0]               restore_slot,
  input  logic                               restore_done_valid,
  output logic                               restore_done_ready,
  input  logic [LOG_SLOTS-1:0]               restore_done_slot,
  output logic                               abort_done_valid,
  input  logic                               abort_done_ready,
  output logic [LOG_SLOTS-1:0]               abort_done_slot,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_count,
  output logic [LOG_SLOTS:0]                 pending_count,
  output logic                               idle,
  output logic                               err_spurious_done
`ifdef RESTORE_SCHED_STATS_EN
  ,
  output logic [31:0]                        stat_issued,
  output logic [31:0]                        stat_coalesced,
  output logic [31:0]                        stat_completed
`endif
);

  localparam int NSLOTS = 1 << LOG_SLOTS;
  localparam int ICW    = $clog2(MAX_INFLIGHT + 1);
  localparam int FAW    = $clog2(DONE_FIFO_DEPTH);
  localparam int FCW    = FAW + 1;
  localparam logic [ICW-1:0]    MAX_IF  = ICW'(MAX_INFLIGHT);
  localparam logic [FCW-1:0]    FIFO_SZ = FCW'(DONE_FIFO_DEPTH);
  localparam logic [NSLOTS-1:0] ONE_HOT = NSLOTS'(1);

  typedef enum logic {ISS_IDLE = 1'b0, ISS_HOLD = 1'b1} iss_state_e;

  iss_state_e               state_q, state_d;
  logic [NSLOTS-1:0]        pending_q, pending_d;
  logic [NSLOTS-1:0]        inflight_q, inflight_d;
  logic [LOG_SLOTS-1:0]     rr_ptr_q, rr_ptr_d;
  logic [LOG_SLOTS-1:0]     restore_slot_q, restore_slot_d;
  logic [ICW-1:0]           inflight_count_q, inflight_count_d;
  logic [LOG_SLOTS:0]       pending_count_q, pending_count_d;
  logic                     err_q, err_d;
  logic [LOG_SLOTS-1:0]     fifo_mem_q [DONE_FIFO_DEPTH];
  logic [LOG_SLOTS-1:0]     fifo_mem_d [DONE_FIFO_DEPTH];
  logic [FAW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FCW-1:0]           fifo_cnt_q, fifo_cnt_d;

  logic                     abort_fire, abort_set, abort_coalesce;
  logic                     done_fire, done_hit;
  logic [NSLOTS-1:0]        inflight_eff, abort_oh, done_oh, issue_oh, pend_cand;
  logic                     sel_found, issue_go;
  logic [LOG_SLOTS-1:0]     sel_slot;
  logic                     fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign abort_ready = ~rst;

  always_comb begin
    fifo_full  = (fifo_cnt_q == FIFO_SZ);
    fifo_empty = (fifo_cnt_q == '0);
    fifo_pop   = ~fifo_empty & abort_done_ready;
    restore_done_ready = ~fifo_full | fifo_pop;

    done_fire = restore_done_valid & restore_done_ready;
    done_hit  = done_fire & inflight_q[restore_done_slot];
    done_oh   = done_hit ? (ONE_HOT << restore_done_slot) : '0;
    fifo_push = done_hit;

    // A slot completing this cycle is no longer in flight, so an abort on it
    // must become pending rather than be coalesced away.
    inflight_eff   = inflight_q & ~done_oh;
    abort_fire     = abort_valid & abort_ready;
    abort_set      = abort_fire & ~pending_q[abort_slot] & ~inflight_eff[abort_slot];
    abort_coalesce = abort_fire & ~abort_set;
    abort_oh       = abort_set ? (ONE_HOT << abort_slot) : '0;

    // Including this cycle's abort gives single-cycle abort-to-issue latency.
    pend_cand = pending_q | abort_oh;
  end

  // Round-robin pick: first candidate at or after rr_ptr, wrapping.
  always_comb begin
    logic [LOG_SLOTS-1:0] idx;
    idx       = '0;
    sel_found = 1'b0;
    sel_slot  = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      idx = rr_ptr_q + LOG_SLOTS'(i);
      if (!sel_found && pend_cand[idx]) begin
        sel_found = 1'b1;
        sel_slot  = idx;
      end
    end
  end

  assign issue_go = (state_q == ISS_IDLE) && sel_found && (inflight_count_q < MAX_IF);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ISS_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ISS_IDLE: if (issue_go) state_d = ISS_HOLD;
      ISS_HOLD: if (restore_ready) state_d = ISS_IDLE;
      default:  state_d = ISS_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    restore_valid = (state_q == ISS_HOLD);
    restore_slot  = restore_slot_q;
  end

  always_comb begin
    issue_oh        = issue_go ? (ONE_HOT << sel_slot) : '0;
    pending_d       = (pending_q | abort_oh) & ~issue_oh;
    inflight_d      = (inflight_q & ~done_oh) | issue_oh;
    rr_ptr_d        = issue_go ? sel_slot + 1'b1 : rr_ptr_q;
    restore_slot_d  = issue_go ? sel_slot : restore_slot_q;
    // Counted at selection so the cap already covers a held request.
    inflight_count_d = inflight_count_q + ICW'(issue_go) - ICW'(done_hit);
    pending_count_d  = pending_count_q + (LOG_SLOTS+1)'(abort_set) - (LOG_SLOTS+1)'(issue_go);
    err_d = err_q | (done_fire & ~inflight_q[restore_done_slot]);

    fifo_mem_d = fifo_mem_q;
    if (fifo_push) fifo_mem_d[wptr_q] = restore_done_slot;
    // When full, push and pop share an address: the head is read this cycle
    // and its entry is reused as the new tail.
    wptr_d     = wptr_q + FAW'(fifo_push);
    rptr_d     = rptr_q + FAW'(fifo_pop);
    fifo_cnt_d = fifo_cnt_q + FCW'(fifo_push) - FCW'(fifo_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q        <= '0;
      inflight_q       <= '0;
      rr_ptr_q         <= '0;
      restore_slot_q   <= '0;
      inflight_count_q <= '0;
      pending_count_q  <= '0;
      err_q            <= 1'b0;
      wptr_q           <= '0;
      rptr_q           <= '0;
      fifo_cnt_q       <= '0;
      for (int i = 0; i < DONE_FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
    end else begin
      pending_q        <= pending_d;
      inflight_q       <= inflight_d;
      rr_ptr_q         <= rr_ptr_d;
      restore_slot_q   <= restore_slot_d;
      inflight_count_q <= inflight_count_d;
      pending_count_q  <= pending_count_d;
      err_q            <= err_d;
      wptr_q           <= wptr_d;
      rptr_q           <= rptr_d;
      fifo_cnt_q       <= fifo_cnt_d;
      fifo_mem_q       <= fifo_mem_d;
    end
  end

  assign abort_done_valid  = ~fifo_empty;
  assign abort_done_slot   = fifo_mem_q[rptr_q];
  assign inflight_count    = inflight_count_q;
  assign pending_count     = pending_count_q;
  assign err_spurious_done = err_q;
  assign idle = ~rst & (pending_q == '0) & (inflight_q == '0) & fifo_empty & ~restore_valid;

`ifdef RESTORE_SCHED_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_coalesced_q, stat_coalesced_d;
  logic [31:0] stat_completed_q, stat_completed_d;

  always_comb begin
    stat_issued_d    = stat_issued_q;
    stat_coalesced_d = stat_coalesced_q;
    stat_completed_d = stat_completed_q;
    if (restore_valid && restore_ready && stat_issued_q != '1) stat_issued_d = stat_issued_q + 32'd1;
    if (abort_coalesce && stat_coalesced_q != '1) stat_coalesced_d = stat_coalesced_q + 32'd1;
    if (fifo_push && stat_completed_q != '1) stat_completed_d = stat_completed_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued_q    <= '0;
      stat_coalesced_q <= '0;
      stat_completed_q <= '0;
    end else begin
      stat_issued_q    <= stat_issued_d;
      stat_coalesced_q <= stat_coalesced_d;
      stat_completed_q <= stat_completed_d;
    end
  end

  assign stat_issued    = stat_issued_q;
  assign stat_coalesced = stat_coalesced_q;
  assign stat_completed = stat_completed_q;
`endif

endmodule

// File: tb/tb_undo_restore_scheduler.sv
module tb_undo_restore_scheduler;

  logic       clk, rst;
  logic       abort_valid, abort_ready;
  logic [5:0] abort_slot;
  logic       restore_valid, restore_ready;
  logic [5:0] restore_slot;
  logic       restore_done_valid, restore_done_ready;
  logic [5:0] restore_done_slot;
  logic       abort_done_valid, abort_done_ready;
  logic [5:0] abort_done_slot;
  logic [2:0] inflight_count;
  logic [6:0] pending_count;
  logic       idle, err_spurious_done;
`ifdef RESTORE_SCHED_STATS_EN
  logic [31:0] stat_issued, stat_coalesced, stat_completed;
`endif

  int total = 0;
  int bad   = 0;

  undo_restore_scheduler #(.LOG_SLOTS(6), .MAX_INFLIGHT(4), .DONE_FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .abort_valid(abort_valid), .abort_ready(abort_ready), .abort_slot(abort_slot),
    .restore_valid(restore_valid), .restore_ready(restore_ready), .restore_slot(restore_slot),
    .restore_done_valid(restore_done_valid), .restore_done_ready(restore_done_ready),
    .restore_done_slot(restore_done_slot),
    .abort_done_valid(abort_done_valid), .abort_done_ready(abort_done_ready),
    .abort_done_slot(abort_done_slot),
    .inflight_count(inflight_count), .pending_count(pending_count),
    .idle(idle), .err_spurious_done(err_spurious_done)
`ifdef RESTORE_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_coalesced(stat_coalesced), .stat_completed(stat_completed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    abort_valid = 1'b0;
    restore_done_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    abort_valid = 1'b0; abort_slot = '0;
    restore_ready = 1'b1;
    restore_done_valid = 1'b0; restore_done_slot = '0;
    abort_done_ready = 1'b1;
    #3;
    chk("rst_abort_ready", abort_ready, 0);
    chk("rst_idle", idle, 0);
    chk("rst_restore_valid", restore_valid, 0);
    chk("rst_abort_done_valid", abort_done_valid, 0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_idle", idle, 1);
    chk("post_rst_abort_ready", abort_ready, 1);
    chk("post_rst_pending", pending_count, 0);
    chk("post_rst_inflight", inflight_count, 0);
    chk("post_rst_err", err_spurious_done, 0);

    // 1: single abort, restore, completion
    abort_valid = 1'b1; abort_slot = 6'd5;
    step();
    abort_valid = 1'b0;
    chk("t1_restore_valid", restore_valid, 1);
    chk("t1_restore_slot", restore_slot, 5);
    chk("t1_inflight", inflight_count, 1);
    chk("t1_pending", pending_count, 0);
    chk("t1_not_idle", idle, 0);
    step();
    chk("t1_restore_drop", restore_valid, 0);
    restore_done_valid = 1'b1; restore_done_slot = 6'd5;
    #1;
    chk("t1_done_ready", restore_done_ready, 1);
    step();
    restore_done_valid = 1'b0;
    chk("t1_abort_done_valid", abort_done_valid, 1);
    chk("t1_abort_done_slot", abort_done_slot, 5);
    chk("t1_inflight_zero", inflight_count, 0);
    step();
    chk("t1_abort_done_pop", abort_done_valid, 0);
    chk("t1_idle_back", idle, 1);

    // 2: six aborts, cap of four in flight
    do_reset();
    restore_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      abort_valid = 1'b1; abort_slot = 6'(i + 1);
      step();
      if (i % 2 == 0) begin
        chk("t2_issue_valid", restore_valid, 1);
        chk("t2_issue_slot", restore_slot, i / 2 + 1);
      end else begin
        chk("t2_gap", restore_valid, 0);
      end
    end
    abort_valid = 1'b0;
    step();
    chk("t2_issue4_valid", restore_valid, 1);
    chk("t2_issue4_slot", restore_slot, 4);
    step();
    chk("t2_cap_a", restore_valid, 0);
    step();
    chk("t2_cap_b", restore_valid, 0);
    chk("t2_inflight4", inflight_count, 4);
    chk("t2_pending2", pending_count, 2);
    restore_done_valid = 1'b1; restore_done_slot = 6'd2;
    step();
    restore_done_valid = 1'b0;
    chk("t2_done_slot", abort_done_slot, 2);
    chk("t2_done_valid", abort_done_valid, 1);
    chk("t2_inflight3", inflight_count, 3);
    chk("t2_no_issue_yet", restore_valid, 0);
    step();
    chk("t2_issue5_valid", restore_valid, 1);
    chk("t2_issue5_slot", restore_slot, 5);
    chk("t2_inflight_back4", inflight_count, 4);
    chk("t2_pending1", pending_count, 1);

    // 3: coalescing duplicates
    do_reset();
    restore_ready = 1'b0;
    abort_valid = 1'b1; abort_slot = 6'd8;
    step();
    chk("t3_hold8", restore_slot, 8);
    abort_slot = 6'd9;
    step();
    chk("t3_pending9", pending_count, 1);
    chk("t3_held_valid", restore_valid, 1);
    chk("t3_held_slot", restore_slot, 8);
    step();
    chk("t3_dup_pending", pending_count, 1);
    abort_valid = 1'b0; restore_ready = 1'b1;
    step();
    chk("t3_handshake", restore_valid, 0);
    step();
    chk("t3_issue9_valid", restore_valid, 1);
    chk("t3_issue9_slot", restore_slot, 9);
    chk("t3_pending0", pending_count, 0);
    chk("t3_inflight2", inflight_count, 2);
    step();
    abort_valid = 1'b1; abort_slot = 6'd9;
    step();
    abort_valid = 1'b0;
    chk("t3_inflight_dup_pending", pending_count, 0);
    step();
    chk("t3_no_reissue", restore_valid, 0);
    chk("t3_inflight_still2", inflight_count, 2);
    restore_done_valid = 1'b1; restore_done_slot = 6'd9;
    abort_valid = 1'b1; abort_slot = 6'd9;
    step();
    restore_done_valid = 1'b0; abort_valid = 1'b0;
    chk("t3_same_cycle_reissue", restore_valid, 1);
    chk("t3_same_cycle_slot", restore_slot, 9);
    chk("t3_same_cycle_inflight", inflight_count, 2);
    chk("t3_same_cycle_done", abort_done_slot, 9);
`ifdef RESTORE_SCHED_STATS_EN
    chk("t3_stat_coalesced", stat_coalesced, 2);
    chk("t3_stat_issued", stat_issued, 2);
    chk("t3_stat_completed", stat_completed, 1);
`endif

    // 4: round-robin wrap
    do_reset();
    restore_ready = 1'b0;
    abort_valid = 1'b1; abort_slot = 6'd61;
    step();
    chk("t4_slot61", restore_slot, 61);
    abort_slot = 6'd0;
    step();
    abort_slot = 6'd63;
    step();
    abort_valid = 1'b0; restore_ready = 1'b1;
    chk("t4_pending2", pending_count, 2);
    step();
    step();
    chk("t4_first_63", restore_slot, 63);
    chk("t4_first_valid", restore_valid, 1);
    step();
    step();
    chk("t4_then_0", restore_slot, 0);
    chk("t4_then_valid", restore_valid, 1);
    chk("t4_inflight3", inflight_count, 3);

    // 5: done FIFO backpressure
    do_reset();
    restore_ready = 1'b1; abort_done_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      abort_valid = 1'b1; abort_slot = 6'(10 + i);
      step();
    end
    abort_valid = 1'b0;
    step(); step(); step();
    chk("t5_inflight4", inflight_count, 4);
    chk("t5_pending1", pending_count, 1);
    restore_done_valid = 1'b1; restore_done_slot = 6'd10;
    #1;
    chk("t5_rdr_first", restore_done_ready, 1);
    step();
    restore_done_valid = 1'b0;
    chk("t5_head10", abort_done_slot, 10);
    step();
    chk("t5_issue14", restore_slot, 14);
    for (int j = 0; j < 3; j++) begin
      restore_done_valid = 1'b1; restore_done_slot = 6'(11 + j);
      step();
    end
    restore_done_slot = 6'd14;
    #1;
    chk("t5_full_blocks", restore_done_ready, 0);
    step();
    chk("t5_still_blocked", restore_done_ready, 0);
    chk("t5_inflight1", inflight_count, 1);
    abort_done_ready = 1'b1;
    #1;
    chk("t5_pop_frees", restore_done_ready, 1);
    chk("t5_head_still10", abort_done_slot, 10);
    step();
    restore_done_valid = 1'b0;
    chk("t5_inflight0", inflight_count, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t5_pop_order", abort_done_slot, 11 + k);
      step();
    end
    chk("t5_fifo_empty", abort_done_valid, 0);
    chk("t5_idle", idle, 1);

    // 6: spurious done, reset mid-hold
    do_reset();
    restore_ready = 1'b1; abort_done_ready = 1'b1;
    restore_done_valid = 1'b1; restore_done_slot = 6'd12;
    step();
    restore_done_valid = 1'b0;
    chk("t6_err_set", err_spurious_done, 1);
    chk("t6_no_done", abort_done_valid, 0);
    chk("t6_count_same", inflight_count, 0);
    step(); step();
    chk("t6_err_sticky", err_spurious_done, 1);
    restore_ready = 1'b0;
    abort_valid = 1'b1; abort_slot = 6'd20;
    step();
    abort_valid = 1'b0;
    chk("t6_hold_valid", restore_valid, 1);
    chk("t6_hold_slot", restore_slot, 20);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", restore_valid, 0);
    chk("t6_rst_idle", idle, 0);
    chk("t6_rst_abort_ready", abort_ready, 0);
    chk("t6_rst_err", err_spurious_done, 0);
    step();
    rst = 1'b0;
    #1;
    chk("t6_after_idle", idle, 1);
    chk("t6_after_valid", restore_valid, 0);
    chk("t6_after_inflight", inflight_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
